// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RISC-V control FSM; MC_ILLEGAL_TRAP_EN enables the illegal-op trap state
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    state_t state_q;
    state_t state_d;
    aluop_t alu_op;

    // State register; reset aborts whatever instruction is in flight, including a held store
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; memory states stall on mem_ready, unused codes fall back to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_BEQ:            state_d = S_BEQ;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:           state_d = S_TRAP;
`else
                    default:           state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:     state_d = S_TRAP;
`else
            S_TRAP:     state_d = S_FETCH;
`endif
            default:    state_d = S_FETCH;
        endcase
    end

    // Datapath controls per state; anything not driven by a state stays at zero
    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ImmSrc    = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        alu_op    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b10;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_LOAD) ? 2'b00 : 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ImmSrc  = 2'b11;
                PCWrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ImmSrc  = 2'b10;
                alu_op  = ALUOP_SUB;
                PCWrite = Zero;
            end
            default: begin
            end
        endcase
    end

    // ALU operation decode; subtract only for R-type with funct7 set
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            ALUOP_SUB: ALUControl = 3'b001;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] && funct7) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    assign state = state_q;

`ifdef MC_ILLEGAL_TRAP_EN
    assign illegal = (state_q == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl (honours MC_ILLEGAL_TRAP_EN)
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7 = 1'b0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ImmSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ALUControl;
    logic [3:0] state;
    logic       illegal;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .state(state), .illegal(illegal)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] rs;
        logic [1:0] imm;
        logic [1:0] asa;
        logic [1:0] asb;
        logic [2:0] alu;
        logic [3:0] st;
        logic       ill;
    } obs_t;

    // Instruction-level model: on DECODE the remaining step list is chosen from the opcode
    int m_state = 0;
    int path[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0;
            path.delete();
        end else if (m_state == 0) begin
            if (mem_ready) m_state = 1;
        end else if (m_state == 11) begin
            m_state = 11;
        end else if ((m_state == 3 || m_state == 5) && !mem_ready) begin
            m_state = m_state;
        end else begin
            if (m_state == 1) begin
                case (op)
                    7'b0000011: path = '{2, 3, 4};
                    7'b0100011: path = '{2, 5};
                    7'b0110011: path = '{6, 7};
                    7'b0010011: path = '{8, 7};
                    7'b1101111: path = '{9, 7};
                    7'b1100011: path = '{10};
`ifdef MC_ILLEGAL_TRAP_EN
                    default:    path = '{11};
`else
                    default:    path.delete();
`endif
                endcase
            end
            m_state = (path.size() > 0) ? path.pop_front() : 0;
        end
    end

    function automatic logic [2:0] funct_alu();
        case (funct3)
            3'b000:  return (op[5] && funct7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic obs_t expect_out(int s);
        obs_t e;
        e = '0;
        e.st = s[3:0];
        case (s)
            0:  begin e.asb = 2'b10; e.rs = 2'b10; e.pcw = mem_ready; e.irw = mem_ready; end
            1:  begin e.asa = 2'b01; e.asb = 2'b01; e.imm = 2'b10; end
            2:  begin e.asa = 2'b10; e.asb = 2'b01; e.imm = (op == 7'b0000011) ? 2'b00 : 2'b01; end
            3:  begin e.adr = 1'b1; end
            4:  begin e.rs = 2'b01; e.rw = 1'b1; end
            5:  begin e.adr = 1'b1; e.mw = 1'b1; end
            6:  begin e.asa = 2'b10; e.alu = funct_alu(); end
            7:  begin e.rw = 1'b1; end
            8:  begin e.asa = 2'b10; e.asb = 2'b01; e.alu = funct_alu(); end
            9:  begin e.asa = 2'b01; e.asb = 2'b10; e.imm = 2'b11; e.pcw = 1'b1; end
            10: begin e.asa = 2'b10; e.imm = 2'b10; e.alu = 3'b001; e.pcw = Zero; end
            11: begin e.ill = 1'b1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // Every falling edge: all outputs must equal the model's prediction
    always @(negedge clk) begin
        obs_t act, exp_v;
        act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ImmSrc,
               ALUSrcA, ALUSrcB, ALUControl, state, illegal};
        exp_v = expect_out(m_state);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t got=%h expected=%h (model state %0d)", $time, act, exp_v, m_state);
        end
    end

    task automatic chk(input string name, input int act, input int exp_v);
        n_tests++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int cyc, mw_cnt, rw_mask, beq_pcw, beq_alu, ex_alu, trap_cyc;

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int fwait, input int mwait, input string name);
        bit left, done;
        int fw, mw;
        op = o; funct3 = f3; funct7 = f7; Zero = z;
        fw = fwait; mw = mwait; left = 0; done = 0;
        cyc = 0; mw_cnt = 0; rw_mask = 0; beq_pcw = -1; beq_alu = -1; ex_alu = -1; trap_cyc = 0;
        for (int k = 0; k < 40; k++) begin
            if (m_state == 0) begin
                mem_ready = (fw > 0) ? 1'b0 : 1'b1;
                if (fw > 0) fw--;
            end else if (m_state == 3 || m_state == 5) begin
                mem_ready = (mw > 0) ? 1'b0 : 1'b1;
                if (mw > 0) mw--;
            end else begin
                mem_ready = k[0];
            end
            @(negedge clk);
            cyc++;
            if (MemWrite) mw_cnt++;
            if (RegWrite) rw_mask |= (1 << state);
            if (state == 4'd10) begin beq_pcw = PCWrite; beq_alu = ALUControl; end
            if (state == 4'd6 || state == 4'd8) ex_alu = ALUControl;
            tick();
            if (m_state != 0) left = 1;
            if (m_state == 11) trap_cyc++;
            if ((left && m_state == 0) || trap_cyc >= 4) begin
                done = 1;
                break;
            end
        end
        if (!done) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        chk("reset_state", state, 0);
        chk("reset_illegal", illegal, 0);
        rst_n = 1'b1;

        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, "lw");
        chk("lw_cycles", cyc, 5);
        chk("lw_regwrite_only_memwb", rw_mask, 16);

        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 3, "sw");
        chk("sw_memwrite_cycles", mw_cnt, 4);
        chk("sw_cycles", cyc, 7);

        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, "beq_taken");
        chk("beq_z1_pcwrite", beq_pcw, 1);
        chk("beq_z1_alu", beq_alu, 1);
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 1, 0, "beq_not_taken");
        chk("beq_z0_pcwrite", beq_pcw, 0);
        chk("beq_z0_alu", beq_alu, 1);

        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, "r_sub");
        chk("r_sub_alu", ex_alu, 1);
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, "i_add");
        chk("i_add_alu", ex_alu, 0);
        run_instr(7'b0010011, 3'b010, 1'b0, 1'b0, 0, 0, "i_slt");
        chk("i_slt_alu", ex_alu, 5);
        run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, 0, 0, "r_or");
        chk("r_or_alu", ex_alu, 3);
        run_instr(7'b0110011, 3'b111, 1'b1, 1'b0, 0, 0, "r_and");
        chk("r_and_alu", ex_alu, 2);

        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 2, 0, "jal");
        chk("jal_cycles", cyc, 6);
        chk("jal_regwrite_aluwb", rw_mask, 128);

        run_instr(7'b0000011, 3'b000, 1'b0, 1'b0, 1, 2, "lw_wait");
        chk("lw_wait_cycles", cyc, 8);

        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, "illegal");
        chk("illegal_no_mem_write", mw_cnt, 0);
        chk("illegal_no_reg_write", rw_mask, 0);
`ifdef MC_ILLEGAL_TRAP_EN
        chk("trap_state", state, 11);
        chk("trap_illegal", illegal, 1);
        do_reset();
        chk("trap_cleared_state", state, 0);
        chk("trap_cleared_illegal", illegal, 0);
`else
        chk("illegal_nop_cycles", cyc, 2);
        chk("illegal_tied_low", illegal, 0);
`endif

        // Asynchronous reset in the middle of a stalled store
        op = 7'b0100011; funct3 = 3'b010; funct7 = 1'b0; Zero = 1'b0;
        mem_ready = 1'b1;
        tick();
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        chk("mid_sw_state", state, 5);
        chk("mid_sw_memwrite", MemWrite, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_state", state, 0);
        chk("async_rst_memwrite", MemWrite, 0);
        chk("async_rst_irwrite_idle", IRWrite, 0);
        #1 mem_ready = 1'b1;
        #1;
        chk("async_rst_pcwrite_ready", PCWrite, 1);
        chk("async_rst_irwrite_ready", IRWrite, 1);
        #1 rst_n = 1'b1;
        op = 7'b0110011; funct3 = 3'b000; funct7 = 1'b0;
        tick();
        chk("post_rst_decode", state, 1);
        tick();
        tick();
        tick();
        chk("post_rst_back_fetch", state, 0);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
